// File: rtl/mem_design_pkg.sv
// Shared types and default sizes for the memory-designs family.
package mem_design_pkg;

  localparam int unsigned param_SIZE       = 4;
  localparam int unsigned param_WIDTH_DATA = 8;
  localparam int unsigned param_WIDTH_ADDR = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MATCH = 2'b01,
    EXEC  = 2'b10
  } cam_state_t;

  typedef enum logic [1:0] {
    CAM_READ   = 2'b00,
    CAM_WRITE  = 2'b01,
    CAM_DELETE = 2'b10,
    CAM_FLUSH  = 2'b11
  } cam_op_t;

endpackage

// File: rtl/cam_match_enc.sv
// Parallel key comparators with lowest-index priority encoders for the hit and free slots.
module cam_match_enc #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WIDTH_ADDR = 8,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH*WIDTH_ADDR-1:0] keys_i,
  input  logic [WIDTH_ADDR-1:0]       addr_i,
  output logic                        hit_any_o,
  output logic [IDX_W-1:0]            hit_idx_o,
  output logic                        free_any_o,
  output logic [IDX_W-1:0]            free_idx_o
);

  logic [DEPTH-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid_i[i] && (keys_i[i*WIDTH_ADDR +: WIDTH_ADDR] == addr_i);
    end
  end

  // Scan downwards so the lowest matching index is the last one assigned.
  always_comb begin
    hit_idx_o  = '0;
    free_idx_o = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx_o = IDX_W'(i);
      if (!valid_i[i]) free_idx_o = IDX_W'(i);
    end
  end

  assign hit_any_o  = |hit_vec;
  assign free_any_o = ~&valid_i;

endmodule

// File: rtl/memory_cam_assoc.sv
// Associative key/value memory: IDLE -> MATCH -> EXEC per request, single-cycle parallel lookup.
module memory_cam_assoc
  import mem_design_pkg::*;
#(
  parameter int unsigned DEPTH       = param_SIZE,
  parameter int unsigned WIDTH_DATA  = param_WIDTH_DATA,
  parameter int unsigned WIDTH_ADDR  = param_WIDTH_ADDR,
  parameter int unsigned ZERO_DELETE = 1,
  parameter int unsigned REPLACE_EN  = 0,
  localparam int unsigned IDX_W      = $clog2(DEPTH),
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [1:0]            op_i,
  input  logic [WIDTH_ADDR-1:0] addr_i,
  input  logic [WIDTH_DATA-1:0] din_i,
  output logic [WIDTH_DATA-1:0] dout_o,
  output logic                  read_valid_o,
  output logic                  hit_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [CNT_W-1:0]      fill_count_o,
  output logic                  write_error_o,
  output logic                  evict_valid_o,
  output logic [WIDTH_ADDR-1:0] evict_addr_o
);

  cam_state_t state_q, state_d;
  cam_op_t op_q;
  logic [WIDTH_ADDR-1:0] addr_q;
  logic [WIDTH_DATA-1:0] din_q;

  logic [WIDTH_ADDR-1:0] key_q  [DEPTH];
  logic [WIDTH_DATA-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH*WIDTH_ADDR-1:0] keys_flat;

  logic hit_any, free_any;
  logic [IDX_W-1:0] hit_idx, free_idx;
  logic m_hit_q, m_free_q;
  logic [IDX_W-1:0] m_hit_idx_q, m_free_idx_q;

  logic [CNT_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0] victim_q, victim_d;
  logic [WIDTH_DATA-1:0] dout_q, dout_d;
  logic [WIDTH_ADDR-1:0] evict_addr_q, evict_addr_d;
  logic read_valid_q, read_valid_d, hit_q, hit_d, done_q, done_d;
  logic werr_q, werr_d, evict_valid_q, evict_valid_d;

  logic wr_en, wr_key;
  logic [IDX_W-1:0] wr_idx;
  logic is_del, is_full;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) keys_flat[i*WIDTH_ADDR +: WIDTH_ADDR] = key_q[i];
  end

  cam_match_enc #(
    .DEPTH     (DEPTH),
    .WIDTH_ADDR(WIDTH_ADDR),
    .IDX_W     (IDX_W)
  ) u_match (
    .valid_i   (valid_q),
    .keys_i    (keys_flat),
    .addr_i    (addr_q),
    .hit_any_o (hit_any),
    .hit_idx_o (hit_idx),
    .free_any_o(free_any),
    .free_idx_o(free_idx)
  );

  assign is_full = (fill_q == CNT_W'(DEPTH));
  // A zero-valued write is a delete and must never allocate a slot.
  assign is_del  = (op_q == CAM_DELETE) ||
                   ((op_q == CAM_WRITE) && (ZERO_DELETE != 0) && (din_q == '0));

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    fill_d        = fill_q;
    victim_d      = victim_q;
    dout_d        = dout_q;
    evict_addr_d  = evict_addr_q;
    read_valid_d  = 1'b0;
    hit_d         = 1'b0;
    done_d        = 1'b0;
    werr_d        = 1'b0;
    evict_valid_d = 1'b0;
    wr_en         = 1'b0;
    wr_key        = 1'b0;
    wr_idx        = '0;
    unique case (state_q)
      IDLE:  if (req_i) state_d = MATCH;
      MATCH: state_d = EXEC;
      EXEC: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q == CAM_FLUSH) begin
          valid_d  = '0;
          fill_d   = '0;
          victim_d = '0;
        end else if (op_q == CAM_READ) begin
          read_valid_d = 1'b1;
          hit_d        = m_hit_q;
          dout_d       = m_hit_q ? data_q[m_hit_idx_q] : '0;
        end else if (is_del) begin
          hit_d = m_hit_q;
          if (m_hit_q) begin
            valid_d[m_hit_idx_q] = 1'b0;
            fill_d               = fill_q - CNT_W'(1);
          end
        end else begin
          hit_d = m_hit_q;
          if (m_hit_q) begin
            wr_en  = 1'b1;
            wr_idx = m_hit_idx_q;
          end else if (m_free_q && !is_full) begin
            wr_en                 = 1'b1;
            wr_key                = 1'b1;
            wr_idx                = m_free_idx_q;
            valid_d[m_free_idx_q] = 1'b1;
            fill_d                = fill_q + CNT_W'(1);
          end else if (REPLACE_EN != 0) begin
            wr_en         = 1'b1;
            wr_key        = 1'b1;
            wr_idx        = victim_q;
            evict_valid_d = 1'b1;
            evict_addr_d  = key_q[victim_q];
            victim_d      = (victim_q == IDX_W'(DEPTH - 1)) ? '0 : victim_q + IDX_W'(1);
          end else begin
            werr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Key/data storage is deliberately unreset; valid_q alone qualifies its contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      data_q[wr_idx] <= din_q;
      if (wr_key) key_q[wr_idx] <= addr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      op_q          <= CAM_READ;
      addr_q        <= '0;
      din_q         <= '0;
      m_hit_q       <= 1'b0;
      m_free_q      <= 1'b0;
      m_hit_idx_q   <= '0;
      m_free_idx_q  <= '0;
      valid_q       <= '0;
      fill_q        <= '0;
      victim_q      <= '0;
      dout_q        <= '0;
      evict_addr_q  <= '0;
      read_valid_q  <= 1'b0;
      hit_q         <= 1'b0;
      done_q        <= 1'b0;
      werr_q        <= 1'b0;
      evict_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_i) begin
        op_q   <= cam_op_t'(op_i);
        addr_q <= addr_i;
        din_q  <= din_i;
      end
      if (state_q == MATCH) begin
        m_hit_q      <= hit_any;
        m_hit_idx_q  <= hit_idx;
        m_free_q     <= free_any;
        m_free_idx_q <= free_idx;
      end
      valid_q       <= valid_d;
      fill_q        <= fill_d;
      victim_q      <= victim_d;
      dout_q        <= dout_d;
      evict_addr_q  <= evict_addr_d;
      read_valid_q  <= read_valid_d;
      hit_q         <= hit_d;
      done_q        <= done_d;
      werr_q        <= werr_d;
      evict_valid_q <= evict_valid_d;
    end
  end

  assign dout_o        = dout_q;
  assign read_valid_o  = read_valid_q;
  assign hit_o         = hit_q;
  assign done_o        = done_q;
  assign busy_o        = (state_q != IDLE);
  assign full_o        = is_full;
  assign almost_full_o = (fill_q == CNT_W'(DEPTH - 1));
  assign fill_count_o  = fill_q;
  assign write_error_o = werr_q;
  assign evict_valid_o = evict_valid_q;
  assign evict_addr_o  = evict_addr_q;

endmodule

// File: tb/tb_memory_cam_assoc.sv
// Directed bench: two instances share stimulus, one rejecting and one evicting on full writes.
module tb_memory_cam_assoc;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, DL = 2'b10, FL = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] addr = '0, din = '0;

  logic [7:0] dout0, dout1, eva0, eva1;
  logic rv0, rv1, hit0, hit1, done0, done1, busy0, busy1, full0, full1;
  logic af0, af1, werr0, werr1, evv0, evv1;
  logic [2:0] fill0, fill1;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  memory_cam_assoc #(.DEPTH(4), .WIDTH_DATA(8), .WIDTH_ADDR(8), .ZERO_DELETE(1), .REPLACE_EN(0))
    dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .addr_i(addr), .din_i(din),
    .dout_o(dout0), .read_valid_o(rv0), .hit_o(hit0), .done_o(done0), .busy_o(busy0),
    .full_o(full0), .almost_full_o(af0), .fill_count_o(fill0), .write_error_o(werr0),
    .evict_valid_o(evv0), .evict_addr_o(eva0)
  );

  memory_cam_assoc #(.DEPTH(4), .WIDTH_DATA(8), .WIDTH_ADDR(8), .ZERO_DELETE(1), .REPLACE_EN(1))
    dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .addr_i(addr), .din_i(din),
    .dout_o(dout1), .read_valid_o(rv1), .hit_o(hit1), .done_o(done1), .busy_o(busy1),
    .full_o(full1), .almost_full_o(af1), .fill_count_o(fill1), .write_error_o(werr1),
    .evict_valid_o(evv1), .evict_addr_o(eva1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request and returns 1ns after the EXEC edge, when results are valid.
  task automatic run(input logic [1:0] o, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; din = d;
    @(posedge clk); #1;
    req = 1'b0;
    chk("busy_after_accept", {31'd0, busy0}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Keys must never match in more than one slot.
  always @(negedge clk) begin
    if (rst_n) begin
      n_assert++;
      assert ($countones(dut0.u_match.hit_vec) <= 1 && $countones(dut1.u_match.hit_vec) <= 1)
      else begin
        n_fail++;
        $error("FAIL unique_key: observed multiple hits expected at most one");
      end
    end
  end

  initial begin
    int dmask;
    int dcnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_dout", {24'd0, dout0}, 32'h0);
    chk("rst_pulses", {26'd0, rv0, hit0, done0, busy0, werr0, evv0}, 32'h0);
    chk("rst_status", {27'd0, full0, af0, fill0}, 32'h0);
    chk("rst_evict_addr", {24'd0, eva1}, 32'h0);
    chk("rst_busy1", {31'd0, busy1}, 32'h0);

    // Write then read back, and a missing key.
    run(WR, 8'h10, 8'hAA);
    chk("wr10_done_hit", {30'd0, done0, hit0}, 32'h2);
    chk("wr10_fill", {29'd0, fill0}, 32'd1);
    chk("wr10_busy_clear", {31'd0, busy0}, 32'h0);
    run(RD, 8'h10, 8'h00);
    chk("rd10", {21'd0, rv0, hit0, done0, dout0}, {21'd0, 3'b111, 8'hAA});
    @(posedge clk); #1;
    chk("rd10_pulses_clear", {29'd0, rv0, hit0, done0}, 32'h0);
    chk("rd10_dout_held", {24'd0, dout0}, 32'hAA);
    run(RD, 8'h11, 8'h00);
    chk("rd11_miss", {22'd0, rv0, hit0, dout0}, {22'd0, 2'b10, 8'h00});

    // Fill to capacity; reject versus evict on a miss when full.
    run(FL, 8'h00, 8'h00);
    chk("flush_fill", {29'd0, fill0}, 32'd0);
    run(WR, 8'h01, 8'h01);
    run(WR, 8'h02, 8'h02);
    run(WR, 8'h03, 8'h03);
    chk("af_at3", {27'd0, full0, af0, fill0}, {27'd0, 2'b01, 3'd3});
    run(WR, 8'h04, 8'h04);
    chk("full_at4", {27'd0, full0, af0, fill0}, {27'd0, 2'b10, 3'd4});
    run(WR, 8'h05, 8'h05);
    chk("wr5_reject", {27'd0, werr0, hit0, fill0}, {27'd0, 2'b10, 3'd4});
    chk("wr5_no_evict0", {31'd0, evv0}, 32'h0);
    chk("wr5_evict1", {20'd0, evv1, werr1, fill1, eva1}, {20'd0, 2'b10, 3'd4, 8'h01});
    run(WR, 8'h02, 8'h55);
    chk("wr2_hit_no_err", {28'd0, werr0, hit0, done0, evv1}, 32'b0110);
    run(RD, 8'h02, 8'h00);
    chk("rd2_both", {dout0, dout1}, 32'h5555);

    // Eviction path after a clean fill.
    run(FL, 8'h00, 8'h00);
    run(WR, 8'h01, 8'h01);
    run(WR, 8'h02, 8'h02);
    run(WR, 8'h03, 8'h03);
    run(WR, 8'h04, 8'h04);
    run(WR, 8'h09, 8'h99);
    chk("wr9_evict", {21'd0, evv1, fill1, eva1}, {21'd0, 1'b1, 3'd4, 8'h01});
    chk("wr9_reject0", {31'd0, werr0}, 32'h1);
    run(RD, 8'h01, 8'h00);
    chk("rd1_evicted", {22'd0, hit1, hit0, dout1}, {22'd0, 2'b01, 8'h00});
    run(RD, 8'h09, 8'h00);
    chk("rd9", {22'd0, hit1, hit0, dout1}, {22'd0, 2'b10, 8'h99});

    // Delete, zero-write delete and lowest-slot reuse.
    run(FL, 8'h00, 8'h00);
    run(WR, 8'h01, 8'h01);
    run(WR, 8'h02, 8'h02);
    run(WR, 8'h03, 8'h03);
    run(WR, 8'h04, 8'h04);
    run(DL, 8'h02, 8'h00);
    chk("del2", {28'd0, hit0, fill0}, {28'd0, 1'b1, 3'd3});
    run(WR, 8'h03, 8'h00);
    chk("zero_del3", {28'd0, hit0, fill0}, {28'd0, 1'b1, 3'd2});
    run(WR, 8'h07, 8'h77);
    chk("wr7_fill", {29'd0, fill0}, 32'd3);
    chk("wr7_slot1", {24'd0, dut0.key_q[1]}, 32'h07);
    run(RD, 8'h07, 8'h00);
    chk("rd7", {23'd0, hit0, dout0}, {23'd0, 1'b1, 8'h77});
    run(WR, 8'h00, 8'h0F);
    run(RD, 8'h00, 8'h00);
    chk("rd_key0", {20'd0, full0, fill0, hit0, dout0}, {20'd0, 1'b1, 3'd4, 1'b1, 8'h0F});
    run(DL, 8'h55, 8'h00);
    chk("del_miss", {27'd0, hit0, werr0, fill0}, {27'd0, 2'b00, 3'd4});

    // Flush empties everything.
    run(FL, 8'h00, 8'h00);
    chk("flush", {26'd0, hit0, done0, full0, fill0}, {26'd0, 3'b010, 3'd0});
    run(RD, 8'h07, 8'h00);
    chk("flush_rd7_miss", {31'd0, hit0}, 32'h0);

    // req held high: accepted at edges 0,3,6, completions at 2,5,8.
    dmask = 0;
    dcnt = 0;
    @(negedge clk);
    req = 1'b1; op = RD; addr = 8'h00;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (e == 8) req = 1'b0;
      if (done0) begin
        dmask = dmask | (1 << e);
        dcnt++;
      end
    end
    chk("held_req_count", dcnt, 32'd3);
    chk("held_req_edges", dmask, 32'h124);

    // Asynchronous reset during MATCH aborts the write.
    run(WR, 8'h01, 8'h11);
    chk("pre_rst_fill", {29'd0, fill0}, 32'd1);
    @(negedge clk);
    req = 1'b1; op = WR; addr = 8'h33; din = 8'h44;
    @(posedge clk); #1;
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_out", {21'd0, busy0, done0, fill0, dout0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (done0) dcnt++;
    end
    chk("midop_no_done", dcnt, 32'd0);
    run(RD, 8'h33, 8'h00);
    chk("midop_no_entry", {28'd0, hit0, fill0}, 32'h0);
    run(RD, 8'h01, 8'h00);
    chk("midop_valid_cleared", {31'd0, hit0}, 32'h0);
    run(WR, 8'h33, 8'h44);
    run(RD, 8'h33, 8'h00);
    chk("post_rst_rd", {20'd0, fill0, hit0, dout0}, {20'd0, 3'd1, 1'b1, 8'h44});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_cam_assoc.md
# memory_cam_assoc

Parametrised associative (content-addressed) sparse memory. It stores up to DEPTH key/value pairs and finds keys with a single-cycle parallel match instead of a sequential or binary search. It supports read, write, explicit delete and flush, and can either reject or evict on a full write. It is the next-generation CAM in the memory-designs family and is driven by the same request/busy style of master as the other memory blocks.

## Interface
Parameters:
- DEPTH, param_SIZE: number of entries; ≥2.
- WIDTH_DATA, param_WIDTH_DATA: value width.
- WIDTH_ADDR, param_WIDTH_ADDR: key width. Key 0 is an ordinary key.
- ZERO_DELETE, 1: when 1, a write with din==0 behaves as delete.
- REPLACE_EN, 0: 0 = a write miss when full raises write_error; 1 = it evicts a round-robin victim.
- Derived: IDX_W=$clog2(DEPTH), CNT_W=$clog2(DEPTH+1).

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk  in  1  clock, rising edge.
  - rst  in  1  asynchronous, active-low reset.
- Request inputs:
  - req  in  1  request, sampled in IDLE.
  - op  in  2  operation: 00 read, 01 write, 10 delete, 11 flush.
  - addr  in  WIDTH_ADDR  key.
  - din  in  WIDTH_DATA  write value.
- Response outputs:
  - dout  out  WIDTH_DATA  read value; 0 on miss.
  - read_valid  out  1  one-cycle pulse marking dout valid.
  - hit  out  1  key was present; valid while done=1.
  - done  out  1  one-cycle completion pulse, every op.
  - busy  out  1  operation in flight; req ignored.
- Status outputs:
  - full  out  1  fill_count==DEPTH.
  - almost_full  out  1  fill_count==DEPTH-1.
  - fill_count  out  CNT_W  number of valid entries.
- Error and eviction outputs:
  - write_error  out  1  one-cycle pulse: write miss while full with REPLACE_EN=0.
  - evict_valid  out  1  one-cycle pulse: an entry was replaced.
  - evict_addr  out  WIDTH_ADDR  key of the replaced entry; valid with evict_valid.

## Operation
- Storage: key[DEPTH], data[DEPTH], valid[DEPTH]. Only valid bits are reset; data and key arrays are not reset.
- FSM (cam_state_t) states: IDLE, MATCH, EXEC.
  - IDLE→MATCH on req: capture op, addr and din into registers.
  - MATCH: register the one-hot hit vector (valid&&key==addr_q), hit_idx, and free_idx (lowest-index invalid slot).
  - MATCH→EXEC unconditionally.
  - EXEC→IDLE unconditionally.
- EXEC behaviour per operation:
  - Read, hit: dout=data[hit_idx], hit=1.
  - Read, miss: dout=0, hit=0.
  - read_valid pulses on both read outcomes.
  - Write, hit: overwrite data[hit_idx]; fill_count unchanged.
  - Write, miss, not full: fill slot free_idx (lowest free index); fill_count+1.
  - Write, miss, full, REPLACE_EN=1: overwrite key and data at victim_ptr; pulse evict_valid with the old key; victim_ptr increments modulo DEPTH.
  - Write, miss, full, REPLACE_EN=0: pulse write_error; no state change.
  - Write with din==0 and ZERO_DELETE=1: handled as delete; never allocates a slot.
  - Delete, hit: clear valid[hit_idx]; fill_count-1.
  - Delete, miss: no-op, hit=0, no error.
  - Flush: clear all valid bits; fill_count=0; victim_ptr=0; hit=0.
- Every op pulses done in EXEC.
- Uniqueness: a key occupies at most one slot. Multiple hits are a design error; a bench assertion checks this, and the RTL uses the lowest-index hit.
- fill_count is a counter, updated only in EXEC. full and almost_full decode it combinationally.

## Timing
- Reset (rst low, asynchronous): FSM=IDLE, all valid=0, fill_count=0, victim_ptr=0.
  - Outputs at reset: dout, read_valid, hit, done, busy, write_error, evict_valid, evict_addr are all 0.
  - full=0; almost_full=(DEPTH==1), so 0 for every legal DEPTH.
- Reset mid-operation aborts the op: no partial write, no done pulse.
- Acceptance: req=1 sampled at edge N while in IDLE.
  - busy=1 after edge N.
  - MATCH result registered at edge N+1.
  - EXEC results (done, dout, read_valid, hit, write_error, evict_*) are registered at edge N+2 and valid for one cycle.
  - busy=0 from edge N+2.
  - Latency is 2 cycles; the next request is sampled at edge N+3, giving a throughput of one op per 3 cycles.
- Handshake rules:
  - req while busy=1 is ignored, not queued.
  - req held high is re-accepted in every IDLE cycle.
  - dout holds its value until the next read completes. All pulse outputs return to 0 the next cycle.
- Status outputs: fill_count, full and almost_full change at the EXEC edge, together with done.
- Width rules: fill_count never wraps; with REPLACE_EN the count stays at DEPTH. victim_ptr wraps DEPTH-1→0 (DEPTH need not be a power of 2).

## Structure
- mem_design_pkg holds: cam_state_t (IDLE, MATCH, EXEC), cam_op_t (CAM_READ, CAM_WRITE, CAM_DELETE, CAM_FLUSH), and the default constants param_SIZE, param_WIDTH_DATA, param_WIDTH_ADDR.
- Sub-module cam_match_enc: parallel comparators plus two priority encoders.
  - Outputs: hit_any, hit_idx, free_any, free_idx.
  - Parametrised by DEPTH, WIDTH_ADDR and IDX_W.
- The top level holds the storage arrays, FSM, counters and victim_ptr.

## Test plan
All scenarios use DEPTH=4, WIDTH_DATA=8, WIDTH_ADDR=8.
- Write/read: write 0x10←0xAA, then read 0x10 → dout=0xAA, hit=1, read_valid one cycle at N+2, fill_count=1. Read 0x11 → dout=0, hit=0.
- Fill and error (REPLACE_EN=0): write keys 1,2,3 → almost_full=1 after the third; write 4 → full=1. Write 5 → write_error pulse, fill_count=4. Write 2←0x55 (hit) → no error.
- Eviction (REPLACE_EN=1): fill keys 1–4, then write 9←0x99 → evict_valid=1, evict_addr=1. Read 1 → miss; read 9 → 0x99.
- Delete and reuse: fill 1–4, delete 2 (fill_count=3), write 0 to key 3 (ZERO_DELETE, fill_count=2), write 7 → occupies the lowest free slot; read 7 hits; key 0 is storable and readable.
- Flush and handshake: flush → fill_count=0, all reads miss. req held high for 10 cycles → exactly 3 done pulses (edges 2, 5, 8); req while busy is dropped.
- Async reset mid-op: assert rst in MATCH during a write → no entry created, all outputs 0. Operation resumes normally after release.
